// File: rtl/exp_series_engine_pkg.sv
// Shared types and constants for the e^x Taylor-series engine.
package exp_series_engine_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_X = 3'd1,
    MUL_C = 3'd2,
    ACC   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] ONE_Q88  = 16'h0100;
  localparam logic [3:0]  LAST_K   = 4'd11;
  localparam int          Q8_SHIFT = 8;

endpackage

// File: rtl/exp_series_engine_q8_mul.sv
// Q8 fixed-point multiply: 24-bit product, shifted right by 8, truncated to 16 bits.
module q8_mul
  import exp_series_engine_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);

  logic [23:0] prod;

  assign prod = 24'(32'(a) * 32'(b));
  assign p    = prod[Q8_SHIFT +: 16];

endmodule

// File: rtl/exp_series_engine.sv
// Iterative Taylor-series evaluator for e^(x/256) in Q8.8, one shared multiplier,
// three cycles per series term.
module exp_series_engine
  import exp_series_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  x,
  output logic [3:0]  coef_addr,
  input  logic [15:0] coef_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  // Handshake: start is a one-cycle request taken only in IDLE; done is a
  // one-cycle pulse with result valid, and result holds until the next start.
  state_t      state;
  state_t      state_nxt;
  logic [7:0]  x_q;
  logic [15:0] term;
  logic [15:0] sum;
  logic [3:0]  k;
  logic [15:0] mul_b;
  logic [15:0] mul_p;
  logic        last_iter;

  assign mul_b     = (state == MUL_C) ? coef_data : {8'h00, x_q};
  assign last_iter = (term == 16'h0000) || (k == LAST_K);
  assign busy      = (state != IDLE);
  assign coef_addr = (state == IDLE) ? 4'd0 : k;

  q8_mul u_mul (
    .a (term),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL_X;
      MUL_X:   state_nxt = MUL_C;
      MUL_C:   state_nxt = ACC;
      ACC:     state_nxt = last_iter ? DONE : MUL_X;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= 8'h00;
      term   <= 16'h0000;
      sum    <= 16'h0000;
      k      <= 4'd0;
      result <= 16'h0000;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q  <= x;
            term <= ONE_Q88;
            sum  <= ONE_Q88;
            k    <= 4'd0;
          end
        end
        MUL_X: term <= mul_p;
        MUL_C: term <= mul_p;
        ACC: begin
          sum <= sum + term;
          // k stays on the last index so coef_addr never passes LAST_K
          if (!last_iter) k <= k + 4'd1;
        end
        DONE: begin
          result <= sum;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_series_engine.sv
// Randomized self-checking bench for exp_series_engine against a per-run series model.
module tb_exp_series_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  x;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        busy;
  logic        done;
  logic [15:0] result;

  always #5 clk = ~clk;

  // External reciprocal table: 256/(addr+1) in Q8.8
  assign coef_data = 16'(256 / (32'(coef_addr) + 32'd1));

  exp_series_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  int n_cmp = 0;
  int n_err = 0;

  // One entry per cycle: {busy, done, coef_addr, result}
  logic [21:0] exp_q[$];
  logic        cur_busy = 1'b0;
  logic        cur_done = 1'b0;
  logic [15:0] cur_res  = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [7:0] xv, output logic [15:0] res, output int n);
    int t;
    int s;
    t = 256;
    s = 256;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      t = ((t * int'(xv)) >> 8) & 16'hFFFF;
      t = ((t * (256 / (k + 1))) >> 8) & 16'hFFFF;
      s = s + t;
      n = k + 1;
      if (t == 0) break;
    end
    res = 16'(s);
  endfunction

  // Expected cycle-by-cycle outputs from the accepted-start edge onward.
  task automatic push_run(input logic [7:0] xv);
    logic [15:0] res;
    int          n;
    logic [3:0]  a;
    model(xv, res, n);
    for (int c = 0; c <= 3 * n + 1; c++) begin
      if (c < 3 * n)       a = 4'(c / 3);
      else if (c == 3 * n) a = 4'(n - 1);
      else                 a = 4'd0;
      exp_q.push_back({(c <= 3 * n), (c == 3 * n + 1), a, (c <= 3 * n) ? cur_res : res});
    end
  endtask

  always @(negedge clk) begin
    logic [21:0] e;
    if (exp_q.size() != 0) begin
      e       = exp_q.pop_front();
      cur_res = e[15:0];
    end else begin
      e = {1'b0, 1'b0, 4'd0, cur_res};
    end
    cur_busy = e[21];
    cur_done = e[20];
    check("busy",      busy,      e[21]);
    check("done",      done,      e[20]);
    check("coef_addr", coef_addr, e[19:16]);
    check("result",    result,    e[15:0]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [7:0] xv);
    start = st;
    x     = xv;
    if (st && !cur_busy && !rst) push_run(xv);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete();
    cur_res  = 16'h0000;
    cur_busy = 1'b0;
    start    = 1'b0;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!cur_busy && exp_q.size() == 0) return;
      tick();
      drive(1'b0, 8'($urandom));
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  task automatic run(input logic [7:0] xv);
    drive(1'b1, xv);
    tick();
    drive(1'b0, 8'($urandom));
    wait_idle();
  endtask

  initial begin
    logic [15:0] mres;
    int          mn;

    // Hand-computed anchors for the model
    model(8'h80, mres, mn);
    check("model_x80_result", mres, 16'h01A5);
    check("model_x80_iters",  mn,   4);
    model(8'h00, mres, mn);
    check("model_x00_result", mres, 16'h0100);
    check("model_x00_iters",  mn,   1);

    start = 1'b0;
    x     = 8'h00;
    do_reset(3);

    run(8'h00);
    check("x00_result", result, 16'h0100);
    run(8'h80);
    check("x80_result", result, 16'h01A5);
    run(8'hFF);

    // Start while busy must be ignored
    drive(1'b1, 8'h80);
    tick();
    drive(1'b0, 8'h00);
    repeat (4) tick();
    drive(1'b1, 8'hFF);
    tick();
    drive(1'b0, 8'h00);
    wait_idle();
    check("ignored_start_result", result, 16'h01A5);

    // Reset mid-run aborts without done
    drive(1'b1, 8'h80);
    repeat (6) tick();
    drive(1'b0, 8'h00);
    do_reset(2);
    run(8'h00);
    check("post_reset_result", result, 16'h0100);

    // Back-to-back: second start in the done cycle
    drive(1'b1, 8'h80);
    tick();
    drive(1'b0, 8'h00);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cur_done) break;
    end
    check("b2b_first_done", cur_done, 1);
    drive(1'b1, 8'h40);
    tick();
    drive(1'b0, 8'h00);
    wait_idle();

    // Random runs with occasional starts while busy and random gaps
    for (int r = 0; r < 30; r++) begin
      drive(1'b1, 8'($urandom));
      tick();
      drive(1'b0, 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 6)) tick();
        drive(1'b1, 8'($urandom));
        tick();
        drive(1'b0, 8'($urandom));
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
